ipsxe_floating_point_const_gen: RTL and testbench

IPSXE_FLOATING_POINT_CONST_GEN -- requirements
Module: ipsxe_floating_point_const_gen

---
 rtl/ipsxe_floating_point_const_gen_pkg.sv | 28 ++
 rtl/ipsxe_floating_point_const_table.sv | 65 ++++++
 rtl/ipsxe_floating_point_const_gen.sv | 143 ++++++++++++++
 tb/tb_ipsxe_floating_point_const_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_const_gen_pkg.sv
// Shared definitions for the floating-point constant generator: FSM encoding,
// table index constants and the exponent bias helper.
package ipsxe_floating_point_const_gen_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_e;

   localparam logic [3:0] IDX_ZERO     = 4'd0;
   localparam logic [3:0] IDX_ONE      = 4'd1;
   localparam logic [3:0] IDX_TWO      = 4'd2;
   localparam logic [3:0] IDX_HALF     = 4'd3;
   localparam logic [3:0] IDX_SIX      = 4'd4;
   localparam logic [3:0] IDX_INF      = 4'd5;
   localparam logic [3:0] IDX_QNAN     = 4'd6;
   localparam logic [3:0] IDX_MAX_NORM = 4'd7;
   localparam logic [3:0] IDX_MIN_NORM = 4'd8;
   localparam logic [3:0] IDX_MIN_SUB  = 4'd9;
   localparam logic [3:0] IDX_THREE    = 4'd10;
   localparam logic [3:0] IDX_ONE_HALF = 4'd11;
   localparam logic [3:0] NUM_CONST    = 4'd12;

   function automatic int unsigned bias_f(input int unsigned exp_width);
      return (32'd1 << (exp_width - 32'd1)) - 32'd1;
   endfunction

endpackage

// File: rtl/ipsxe_floating_point_const_table.sv
// Combinational constant table: index + negate request -> {sign, exp, man}.
module ipsxe_floating_point_const_table
   import ipsxe_floating_point_const_gen_pkg::*;
#(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 23,
   localparam int W = 1 + EXP_WIDTH + MAN_WIDTH
) (
   input  logic [3:0]   idx,
   input  logic         neg,
   output logic [W-1:0] value
);

   localparam logic [EXP_WIDTH-1:0] BIAS     = EXP_WIDTH'(bias_f(EXP_WIDTH));
   localparam logic [EXP_WIDTH-1:0] EXP_ONE  = EXP_WIDTH'(1);
   localparam logic [EXP_WIDTH-1:0] EXP_TWO  = EXP_WIDTH'(2);
   localparam logic [EXP_WIDTH-1:0] EXP_ONES = {EXP_WIDTH{1'b1}};
   localparam logic [MAN_WIDTH-1:0] MAN_MSB  = {1'b1, {(MAN_WIDTH-1){1'b0}}};
   localparam logic [MAN_WIDTH-1:0] MAN_ONES = {MAN_WIDTH{1'b1}};
   localparam logic [MAN_WIDTH-1:0] MAN_LSB  = MAN_WIDTH'(1);

   logic                 sign_s;
   logic [EXP_WIDTH-1:0] exp_s;
   logic [MAN_WIDTH-1:0] man_s;

   // Positive-form entry lookup; the canonical NaN never takes the negation.
   always_comb begin
      exp_s  = {EXP_WIDTH{1'b0}};
      man_s  = {MAN_WIDTH{1'b0}};
      sign_s = neg && (idx != IDX_QNAN);
      case (idx)
         IDX_ZERO:     exp_s = {EXP_WIDTH{1'b0}};
         IDX_ONE:      exp_s = BIAS;
         IDX_TWO:      exp_s = BIAS + EXP_ONE;
         IDX_HALF:     exp_s = BIAS - EXP_ONE;
         IDX_SIX: begin
            exp_s = BIAS + EXP_TWO;
            man_s = MAN_MSB;
         end
         IDX_INF:      exp_s = EXP_ONES;
         IDX_QNAN: begin
            exp_s = EXP_ONES;
            man_s = MAN_MSB;
         end
         IDX_MAX_NORM: begin
            exp_s = EXP_ONES - EXP_ONE;
            man_s = MAN_ONES;
         end
         IDX_MIN_NORM: exp_s = EXP_ONE;
         IDX_MIN_SUB:  man_s = MAN_LSB;
         IDX_THREE: begin
            exp_s = BIAS + EXP_ONE;
            man_s = MAN_MSB;
         end
         IDX_ONE_HALF: begin
            exp_s = BIAS;
            man_s = MAN_MSB;
         end
         default:      exp_s = {EXP_WIDTH{1'b0}};
      endcase
   end

   assign value = {sign_s, exp_s, man_s};

endmodule

// File: rtl/ipsxe_floating_point_const_gen.sv
// Floating-point constant generator: single-slot ready/valid lookup port plus
// an autonomous sweep that streams every defined table entry.
module ipsxe_floating_point_const_gen
   import ipsxe_floating_point_const_gen_pkg::*;
#(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 23,
   parameter int TAG_WIDTH = 4,
   localparam int W = 1 + EXP_WIDTH + MAN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [3:0]           req_addr,
   input  logic                 req_neg,
   input  logic [TAG_WIDTH-1:0] req_tag,
   input  logic                 sweep_start,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_sweep,
   output logic                 sweep_done,
   output logic                 busy
);

   state_e               state_q, state_d;
   logic [3:0]           idx_q, idx_d;
   logic                 out_valid_q, out_valid_d;
   logic [W-1:0]         out_data_q, out_data_d;
   logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
   logic                 out_sweep_q, out_sweep_d;
   logic                 sweep_done_q, sweep_done_d;

   logic                 req_ready_s;
   logic                 slot_free_s;
   logic [3:0]           tbl_idx_s;
   logic                 tbl_neg_s;
   logic [W-1:0]         tbl_value_s;

   ipsxe_floating_point_const_table #(
      .EXP_WIDTH (EXP_WIDTH),
      .MAN_WIDTH (MAN_WIDTH)
   ) u_table (
      .idx   (tbl_idx_s),
      .neg   (tbl_neg_s),
      .value (tbl_value_s)
   );

   // Next-state, output-slot loading and request handshake.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_tag_d    = out_tag_q;
      out_sweep_d  = out_sweep_q;
      sweep_done_d = 1'b0;
      req_ready_s  = 1'b0;
      tbl_idx_s    = req_addr;
      tbl_neg_s    = req_neg;
      slot_free_s  = !out_valid_q || out_ready;

      case (state_q)
         ST_IDLE: begin
            req_ready_s = !rst && !sweep_start && slot_free_s;
            if (req_valid && req_ready_s) begin
               out_valid_d = 1'b1;
               out_data_d  = tbl_value_s;
               out_tag_d   = req_tag;
               out_sweep_d = 1'b0;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end else begin
               out_valid_d = out_valid_q;
            end
            // A pending beat is left in the slot and drains during the sweep.
            if (sweep_start) begin
               state_d = ST_SWEEP;
               idx_d   = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            tbl_idx_s = idx_q;
            tbl_neg_s = 1'b0;
            // Once every entry is loaded, the beat in the slot is the last one.
            if ((idx_q == NUM_CONST) && out_valid_q && out_ready) begin
               state_d      = ST_IDLE;
               idx_d        = 4'd0;
               out_valid_d  = 1'b0;
               sweep_done_d = 1'b1;
            end else if (slot_free_s && (idx_q < NUM_CONST)) begin
               out_valid_d = 1'b1;
               out_data_d  = tbl_value_s;
               out_tag_d   = TAG_WIDTH'(idx_q);
               out_sweep_d = 1'b1;
               idx_d       = idx_q + 4'd1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 4'd0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 4'd0;
         out_valid_q  <= 1'b0;
         out_data_q   <= {W{1'b0}};
         out_tag_q    <= {TAG_WIDTH{1'b0}};
         out_sweep_q  <= 1'b0;
         sweep_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_tag_q    <= out_tag_d;
         out_sweep_q  <= out_sweep_d;
         sweep_done_q <= sweep_done_d;
      end
   end

   assign req_ready  = req_ready_s;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_tag    = out_tag_q;
   assign out_sweep  = out_sweep_q;
   assign sweep_done = sweep_done_q;
   assign busy       = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_ipsxe_floating_point_const_gen.sv
// Self-checking bench: transaction-level model with a per-cycle compare process,
// directed literal vectors and randomized traffic.
module tb_ipsxe_floating_point_const_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_neg, sweep_start;
   logic [3:0]  req_addr, req_tag, out_tag;
   logic        out_valid, out_ready, out_sweep, sweep_done, busy;
   logic [31:0] out_data;

   logic        h_req_valid, h_req_ready, h_req_neg, h_sweep_start;
   logic [3:0]  h_req_addr, h_req_tag, h_out_tag;
   logic        h_out_valid, h_out_ready, h_out_sweep, h_sweep_done, h_busy;
   logic [15:0] h_out_data;

   int n_chk  = 0;
   int n_pass = 0;
   int done_cnt = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   ipsxe_floating_point_const_gen dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_neg(req_neg), .req_tag(req_tag),
      .sweep_start(sweep_start), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .out_sweep(out_sweep),
      .sweep_done(sweep_done), .busy(busy)
   );

   ipsxe_floating_point_const_gen #(.EXP_WIDTH(5), .MAN_WIDTH(10), .TAG_WIDTH(4)) dut_h (
      .clk(clk), .rst(rst), .req_valid(h_req_valid), .req_ready(h_req_ready),
      .req_addr(h_req_addr), .req_neg(h_req_neg), .req_tag(h_req_tag),
      .sweep_start(h_sweep_start), .out_valid(h_out_valid), .out_ready(h_out_ready),
      .out_data(h_out_data), .out_tag(h_out_tag), .out_sweep(h_out_sweep),
      .sweep_done(h_sweep_done), .busy(h_busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference value straight from the table rules, any format.
   function automatic logic [63:0] model_val(input int addr, input bit neg, input int ew, input int mw);
      longint bias = (longint'(1) << (ew - 1)) - 1;
      longint emax = (longint'(1) << ew) - 1;
      longint top  = longint'(1) << (mw - 1);
      longint e = 0, m = 0, s;
      case (addr)
         1: e = bias;
         2: e = bias + 1;
         3: e = bias - 1;
         4: begin e = bias + 2; m = top; end
         5: e = emax;
         6: begin e = emax; m = top; end
         7: begin e = emax - 1; m = (longint'(1) << mw) - 1; end
         8: e = 1;
         9: m = 1;
         10: begin e = bias + 1; m = top; end
         11: begin e = bias; m = top; end
         default: ;
      endcase
      s = (neg && addr != 6) ? 1 : 0;
      return 64'((s << (ew + mw)) | (e << mw) | m);
   endfunction

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      bit          sweep;
      int          idx;
   } beat_t;

   beat_t exp_q[$];
   bit    m_sweep = 1'b0;
   int    m_idx   = 0;
   bit    m_done  = 1'b0;

   // Per-cycle compare against the transaction model, then advance the model.
   always @(negedge clk) begin
      if (mon_en) begin
         logic  exp_ready;
         bit    accepted, done_next;
         beat_t b, popped;
         logic [63:0] v;
         if (sweep_done === 1'b1) done_cnt++;
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0].data));
            chk("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
            chk("out_sweep", 64'(out_sweep), 64'(exp_q[0].sweep));
         end
         chk("busy", 64'(busy), 64'(m_sweep));
         chk("sweep_done", 64'(sweep_done), 64'(m_done));
         exp_ready = !rst && !m_sweep && !sweep_start && (exp_q.size() == 0 || out_ready);
         chk("req_ready", 64'(req_ready), 64'(exp_ready));

         done_next = 1'b0;
         if (rst) begin
            exp_q.delete();
            m_sweep = 1'b0;
            m_idx   = 0;
         end else begin
            accepted = (exp_q.size() != 0) && out_ready;
            popped.sweep = 1'b0;
            popped.idx   = -1;
            if (accepted) popped = exp_q.pop_front();
            if (!m_sweep) begin
               if (exp_ready && req_valid) begin
                  v = model_val(int'(req_addr), req_neg, 8, 23);
                  b.data = v[31:0]; b.tag = req_tag; b.sweep = 1'b0; b.idx = -1;
                  exp_q.push_back(b);
               end
               if (sweep_start) begin
                  m_sweep = 1'b1;
                  m_idx   = 0;
               end
            end else if (accepted && popped.sweep && popped.idx == 11) begin
               m_sweep   = 1'b0;
               done_next = 1'b1;
            end else if (exp_q.size() == 0 && m_idx < 12) begin
               v = model_val(m_idx, 1'b0, 8, 23);
               b.data = v[31:0]; b.tag = 4'(m_idx); b.sweep = 1'b1; b.idx = m_idx;
               exp_q.push_back(b);
               m_idx++;
            end
         end
         m_done = done_next;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [3:0] addr, input logic neg, input logic [3:0] tag,
                         input logic [31:0] lit, input string name);
      req_valid = 1'b1; req_addr = addr; req_neg = neg; req_tag = tag;
      step();
      req_valid = 1'b0;
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk(name, 64'(out_data), 64'(lit));
      chk({name, "_tag"}, 64'(out_tag), 64'(tag));
   endtask

   task automatic do_h(input logic [3:0] addr, input logic neg, input logic [15:0] lit, input string name);
      logic [63:0] v;
      h_req_valid = 1'b1; h_req_addr = addr; h_req_neg = neg;
      step();
      h_req_valid = 1'b0;
      v = model_val(int'(addr), neg, 5, 10);
      chk(name, 64'(h_out_data), 64'(lit));
      chk({name, "_model"}, 64'(h_out_data), v);
   endtask

   initial begin
      logic [31:0] held;
      logic [63:0] v;
      int d0;
      rst = 1'b1; req_valid = 1'b0; req_addr = 4'd0; req_neg = 1'b0; req_tag = 4'd0;
      sweep_start = 1'b0; out_ready = 1'b1;
      h_req_valid = 1'b0; h_req_addr = 4'd0; h_req_neg = 1'b0; h_req_tag = 4'd0;
      h_sweep_start = 1'b0; h_out_ready = 1'b1;

      chk("pin_one", model_val(1, 1'b0, 8, 23), 64'h3F80_0000);
      chk("pin_neg_six", model_val(4, 1'b1, 8, 23), 64'hC0C0_0000);
      chk("pin_h_inf", model_val(5, 1'b0, 5, 10), 64'h7C00);

      step();
      mon_en = 1'b1;
      step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_sweep", 64'(out_sweep), 64'd0);
      chk("rst_sweep_done", 64'(sweep_done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      step();

      do_req(4'd1, 1'b0, 4'd3, 32'h3F80_0000, "one");
      chk("one_sweep", 64'(out_sweep), 64'd0);
      do_req(4'd4, 1'b1, 4'd1, 32'hC0C0_0000, "neg_six");
      do_req(4'd6, 1'b1, 4'd2, 32'h7FC0_0000, "nan_neg");
      do_req(4'd7, 1'b0, 4'd4, 32'h7F7F_FFFF, "max_norm");
      do_req(4'd9, 1'b0, 4'd5, 32'h0000_0001, "min_sub");
      do_req(4'd13, 1'b0, 4'd6, 32'h0000_0000, "reserved");
      do_h(4'd1, 1'b0, 16'h3C00, "h_one");
      do_h(4'd5, 1'b0, 16'h7C00, "h_inf");
      do_h(4'd4, 1'b1, 16'hC600, "h_neg_six");

      // Stall: slot must hold and refuse new requests.
      out_ready = 1'b0;
      do_req(4'd2, 1'b0, 4'd7, 32'h4000_0000, "two");
      held = out_data;
      req_valid = 1'b1; req_addr = 4'd3;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_data", 64'(out_data), 64'(held));
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_ready", 64'(req_ready), 64'd0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_addr = 4'(i); req_tag = 4'(i); req_neg = i[0];
         step();
         v = model_val(i, i[0], 8, 23);
         chk("b2b_valid", 64'(out_valid), 64'd1);
         chk("b2b_tag", 64'(out_tag), 64'(i));
         chk("b2b_data", 64'(out_data), v);
      end
      req_valid = 1'b0;
      step();

      // Full sweep with a second start pulse mid-way.
      d0 = done_cnt;
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      chk("sweep_busy0", 64'(busy), 64'd1);
      for (int b = 0; b < 12; b++) begin
         sweep_start = (b == 4);
         step();
         chk("sweep_valid", 64'(out_valid), 64'd1);
         chk("sweep_flag", 64'(out_sweep), 64'd1);
         chk("sweep_tag", 64'(out_tag), 64'(b));
         chk("sweep_busy", 64'(busy), 64'd1);
      end
      sweep_start = 1'b0;
      step();
      chk("sweep_done_pulse", 64'(sweep_done), 64'd1);
      chk("sweep_idle", 64'(busy), 64'd0);
      step();
      chk("sweep_done_clear", 64'(sweep_done), 64'd0);
      chk("sweep_done_once", 64'(done_cnt - d0), 64'd1);

      // Reset in the middle of a sweep.
      d0 = done_cnt;
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      for (int b = 0; b < 6; b++) step();
      chk("abort_tag5", 64'(out_tag), 64'd5);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(sweep_done), 64'd0);
      step();
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      do_req(4'd11, 1'b1, 4'd9, 32'hBFC0_0000, "after_rst");

      // Randomized traffic checked by the compare process.
      for (int i = 0; i < 2000; i++) begin
         req_valid   = ($urandom_range(0, 1) == 1);
         req_addr    = 4'($urandom_range(0, 15));
         req_neg     = ($urandom_range(0, 1) == 1);
         req_tag     = 4'($urandom_range(0, 15));
         out_ready   = ($urandom_range(0, 3) != 0);
         sweep_start = ($urandom_range(0, 39) == 0);
         rst         = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0; req_valid = 1'b0; sweep_start = 1'b0; out_ready = 1'b1;
      step();
      step();
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
